// File: rtl/keyvalue_scan.sv
// Key-value store with a sequential scan FSM: one table entry is compared per cycle.
// Wishbone-classic request/ACK handshake; lookup, insert/update, delete and clear opcodes.
module keyvalue_scan #(
  parameter  int KEY_W = 16,
  parameter  int VAL_W = 16,
  parameter  int DEPTH = 8,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             sys_clk,
  input  logic             sys_rst_1,
  input  logic             STB_i,
  input  logic             CYC_i,
  input  logic [1:0]       OP_i,
  input  logic [KEY_W-1:0] KEY_i,
  input  logic [VAL_W-1:0] DAT_i,
  output logic             ACK_o,
  output logic [VAL_W-1:0] DAT_o,
  output logic             HIT_o,
  output logic             DUP_o,
  output logic             ERR_o,
  output logic             FULL_o,
  output logic [CNT_W-1:0] COUNT_o,
  output logic [31:0]      LA_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [1:0] OP_LOOKUP = 2'd0;
  localparam logic [1:0] OP_INSERT = 2'd1;
  localparam logic [1:0] OP_DELETE = 2'd2;
  localparam logic [1:0] OP_CLEAR  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] free_idx_q, free_idx_d;
  logic             free_found_q, free_found_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ack_q, ack_d;
  logic             hit_q, hit_d;
  logic             dup_q, dup_d;
  logic             err_q, err_d;
  logic [VAL_W-1:0] dat_q, dat_d;

  logic [1:0]       op_q, op_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [VAL_W-1:0] val_q, val_d;

  logic [KEY_W-1:0] keys_q [DEPTH];
  logic [VAL_W-1:0] vals_q [DEPTH];

  logic             wr_key, wr_val;
  logic [IDX_W-1:0] wr_idx;

  logic             match, last, slot_free;
  logic [IDX_W-1:0] alloc_idx;

  assign match     = valid_q[idx_q] && (keys_q[idx_q] == key_q);
  assign last      = (idx_q == IDX_W'(DEPTH - 1));
  // The entry under scan counts as a free slot on the final cycle as well.
  assign slot_free = free_found_q | ~valid_q[idx_q];
  assign alloc_idx = free_found_q ? free_idx_q : idx_q;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    free_idx_d   = free_idx_q;
    free_found_d = free_found_q;
    valid_d      = valid_q;
    count_d      = count_q;
    ack_d        = 1'b0;
    hit_d        = hit_q;
    dup_d        = dup_q;
    err_d        = err_q;
    dat_d        = dat_q;
    op_d         = op_q;
    key_d        = key_q;
    val_d        = val_q;
    wr_key       = 1'b0;
    wr_val       = 1'b0;
    wr_idx       = idx_q;

    case (state_q)
      IDLE: begin
        if (STB_i && CYC_i) begin
          op_d  = OP_i;
          key_d = KEY_i;
          val_d = DAT_i;
          if (OP_i == OP_CLEAR) begin
            state_d = RESP;
            ack_d   = 1'b1;
            valid_d = '0;
            count_d = '0;
            hit_d   = 1'b0;
            dup_d   = 1'b0;
            err_d   = 1'b0;
            dat_d   = '0;
          end else begin
            idx_d        = '0;
            free_found_d = 1'b0;
            state_d      = SCAN;
          end
        end
      end

      SCAN: begin
        if (!free_found_q && !valid_q[idx_q]) begin
          free_found_d = 1'b1;
          free_idx_d   = idx_q;
        end
        // Results and storage commit on entry to RESP so they are visible with ACK.
        if (match || last) begin
          state_d = RESP;
          ack_d   = 1'b1;
          hit_d   = match;
          dup_d   = 1'b0;
          err_d   = 1'b0;
          dat_d   = '0;
          case (op_q)
            OP_LOOKUP: begin
              if (match) dat_d = vals_q[idx_q];
            end
            OP_INSERT: begin
              if (match) begin
                dup_d  = 1'b1;
                dat_d  = val_q;
                wr_val = 1'b1;
              end else if (slot_free) begin
                wr_key             = 1'b1;
                wr_val             = 1'b1;
                wr_idx             = alloc_idx;
                valid_d[alloc_idx] = 1'b1;
                count_d            = count_q + CNT_W'(1);
                dat_d              = val_q;
              end else begin
                err_d = 1'b1;
              end
            end
            OP_DELETE: begin
              if (match) begin
                valid_d[idx_q] = 1'b0;
                count_d        = count_q - CNT_W'(1);
                dat_d          = vals_q[idx_q];
              end
            end
            default: ;
          endcase
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_1) begin
    if (!sys_rst_1) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      free_idx_q   <= '0;
      free_found_q <= 1'b0;
      valid_q      <= '0;
      count_q      <= '0;
      ack_q        <= 1'b0;
      hit_q        <= 1'b0;
      dup_q        <= 1'b0;
      err_q        <= 1'b0;
      dat_q        <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      free_idx_q   <= free_idx_d;
      free_found_q <= free_found_d;
      valid_q      <= valid_d;
      count_q      <= count_d;
      ack_q        <= ack_d;
      hit_q        <= hit_d;
      dup_q        <= dup_d;
      err_q        <= err_d;
      dat_q        <= dat_d;
    end
  end

  // Request latches and table contents carry no reset; valid_q qualifies them.
  always_ff @(posedge sys_clk) begin
    op_q  <= op_d;
    key_q <= key_d;
    val_q <= val_d;
    if (wr_key) keys_q[wr_idx] <= key_q;
    if (wr_val) vals_q[wr_idx] <= val_q;
  end

  assign ACK_o   = ack_q;
  assign DAT_o   = dat_q;
  assign HIT_o   = hit_q;
  assign DUP_o   = dup_q;
  assign ERR_o   = err_q;
  assign COUNT_o = count_q;
  assign FULL_o  = (count_q == CNT_W'(DEPTH));
  assign LA_o    = {14'd0, 8'(count_q), 8'(idx_q), state_q};

endmodule
